// File: rtl/add_accumulator.sv
// add_accumulator: multi-beat add/subtract accumulator with sticky carry and
// overflow flags, valid/ready operand input and a held result until accepted.
module add_accumulator #(
  parameter int N   = 4,
  parameter int LEN = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         clear,
  input  logic         sub,
  input  logic         in_valid,
  input  logic [N-1:0] num,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] acc,
  output logic         carry,
  output logic         overflow,
  output logic         zero,
  output logic         negative,
  output logic         busy
);

  // Beat counter is sized to hold the value LEN.
  localparam int CW = $clog2(LEN + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] beat_cnt;
  logic          sub_q;

  logic          start_fire;
  logic          beat_fire;
  logic          last_beat;
  logic [N-1:0]  opnd;
  logic [N:0]    sum;
  logic [N-1:0]  sum_acc;
  logic          sum_c;
  logic          step_carry;
  logic          step_ovf;

  // Clear outranks both a new start and an operand beat.
  assign start_fire = (state == IDLE) && start && !clear;
  assign beat_fire  = (state == ACCUM) && in_valid && !clear;
  assign last_beat  = (beat_cnt == LAST_BEAT);

  // Subtraction is done as acc + ~num + 1, so the carry-in equals the op select.
  assign opnd    = sub_q ? ~num : num;
  assign sum     = {1'b0, acc} + {1'b0, opnd} + {{N{1'b0}}, sub_q};
  assign sum_acc = sum[N-1:0];
  assign sum_c   = sum[N];

  // A subtract borrows when no carry comes out of the top bit.
  assign step_carry = sub_q ? ~sum_c : sum_c;
  assign step_ovf   = (acc[N-1] == opnd[N-1]) && (sum_acc[N-1] != acc[N-1]);

  assign zero     = (acc == '0);
  assign negative = acc[N-1];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and state-derived handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && last_beat) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (clear) begin
      state_next = IDLE;
    end
  end

  // Accumulator, sticky flags, beat counter and latched operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      beat_cnt <= '0;
      sub_q    <= 1'b0;
    end else if (start_fire) begin
      acc      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      beat_cnt <= '0;
      sub_q    <= sub;
    end else if (beat_fire) begin
      acc      <= sum_acc;
      carry    <= carry | step_carry;
      overflow <= overflow | step_ovf;
      beat_cnt <= beat_cnt + CW'(1);
    end
  end

endmodule
